// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transceiver (TX and RX paths).
//   - tx_state_e         : transmit frame FSM states
//   - PAR_EVEN / PAR_ODD : encodings of the PAR_TYP input
//   - DEFAULT_DATA_WIDTH : data bits per frame unless overridden
//   - PRESCALE_WIDTH     : width of the bit-period (prescale) value
// Optional feature macro used by the TX path: UART_TX_PARITY_EN.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int PRESCALE_WIDTH     = 5;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if
// Parallel request side and serial output of the UART transmitter.
//   P_DATA     : byte to send, sampled on acceptance
//   Data_Valid : request to send P_DATA, honoured only while idle
//   PAR_EN     : append a parity bit (sampled on acceptance)
//   PAR_TYP    : 0 = even, 1 = odd parity (sampled on acceptance)
//   prescale   : bit period minus one, in clock cycles
//   TX_OUT     : serial line, idle high
//   Busy       : a frame is in progress
// Modports: master = requester side, slave = transmitter side.
interface uart_tx_frame_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      TX_OUT;
    logic                      Busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        output prescale,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        input  prescale,
        output TX_OUT,
        output Busy
    );

endinterface

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer
// Bit-period counter for the UART transmitter. Counts 0..prescale while
// enabled and pulses bit_done for one cycle on the last cycle of each bit,
// so every bit lasts prescale+1 clock cycles.
//   CLK      : system clock
//   RST      : asynchronous active-high reset
//   enable   : count while high; held at zero otherwise
//   prescale : latched bit period minus one
//   bit_done : single-cycle pulse marking the final cycle of a bit
module uart_tx_bit_timer
    import uart_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_done
);

    logic [PRESCALE_WIDTH-1:0] count_q;

    assign bit_done = enable && (count_q == prescale);

    // Clearing on bit_done starts the next bit from zero; clearing while
    // disabled guarantees the first bit of a frame gets its full period.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else if (!enable || bit_done) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// UART transmitter: accepts one parallel word per handshake while idle and
// sends start bit, data bits LSB first, optional parity bit and one stop bit.
// Each bit lasts prescale+1 clock cycles.
//   CLK : system clock, rising edge
//   RST : asynchronous active-high reset (line returns high, Busy low)
//   bus : uart_tx_frame_if.slave (P_DATA, Data_Valid, PAR_EN, PAR_TYP,
//         prescale in; TX_OUT, Busy out, both registered)
// Build option: define UART_TX_PARITY_EN to include the parity state and
// parity logic. Without it PAR_EN/PAR_TYP are ignored and every frame is
// DATA_WIDTH+2 bits.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
)
(
    input  logic             CLK,
    input  logic             RST,
    uart_tx_frame_if.slave   bus
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e state_q;
    tx_state_e state_d;

    logic [DATA_WIDTH-1:0]     data_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [CNT_W-1:0]          bit_cnt_q;
    logic [CNT_W-1:0]          bit_cnt_d;
    logic                      accept;
    logic                      bit_done;
    logic                      tx_q;
    logic                      tx_d;
    logic                      busy_q;
    logic                      busy_d;

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_typ_q;
    logic parity_bit;

    assign parity_bit = (par_typ_q == PAR_ODD) ? ~(^data_q) : (^data_q);
`else
    logic par_inputs_unused;

    assign par_inputs_unused = bus.PAR_EN ^ bus.PAR_TYP;
`endif

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;

    uart_tx_bit_timer u_bit_timer (
        .CLK      (CLK),
        .RST      (RST),
        .enable   (state_q != IDLE),
        .prescale (prescale_q),
        .bit_done (bit_done)
    );

    // Frame parameters are captured only at acceptance so that anything the
    // requester changes mid-frame cannot disturb the frame on the line.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q     <= '0;
            prescale_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
`endif
        end else if (accept) begin
            data_q     <= bus.P_DATA;
            prescale_q <= bus.prescale;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= bus.PAR_EN;
            par_typ_q  <= bus.PAR_TYP;
`endif
        end
    end

    // State, bit index and the registered line outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    // Next state and next bit index. A bit only ends on bit_done, so every
    // state other than IDLE holds for exactly one bit period per step.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Data_Valid) begin
                    accept  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? PARITY : STOP;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line value is decoded from the state being entered, so the registered
    // output changes on the same edge as the state with no extra latency.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);

        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = data_q[bit_cnt_d];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = parity_bit;
`endif
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
// Directed bench for uart_tx_frame. Stimulus pushes hand-computed frames
// (bit 0 = first bit on the line) into a queue; a monitor captures each
// Busy window cycle by cycle and compares it with the queue head.
// Expected frames follow the UART_TX_PARITY_EN setting of the build.
module tb_uart_tx_frame;
    import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_BUILD = 1'b1;
`else
    localparam bit PARITY_BUILD = 1'b0;
`endif

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          prescale;
        bit          check_gap;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;

    uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic cap_bits[$];
    bit   capturing = 1'b0;
    int   idle_cnt = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareFrame();
        exp_t e;
        int   per;
        if (exp_q.size() == 0) begin
            checkOutput("unexpected_frame", 32'(cap_bits.size()), 32'd0);
            return;
        end
        e   = exp_q.pop_front();
        per = e.prescale + 1;
        checkOutput("frame_len", 32'(cap_bits.size()), 32'(e.nbits * per));
        for (int i = 0; i < cap_bits.size() && i < e.nbits * per; i++) begin
            checkOutput($sformatf("bit%0d_cyc%0d", i / per, i),
                        32'(cap_bits[i]), 32'(e.bits[i / per]));
        end
    endtask

    // Monitor: one sample per cycle on the falling edge.
    always @(negedge CLK) begin
        if (RST) begin
            capturing = 1'b0;
            cap_bits.delete();
            idle_cnt = 0;
        end else if (bus.Busy === 1'b1) begin
            if (!capturing) begin
                capturing = 1'b1;
                cap_bits.delete();
                if (exp_q.size() > 0 && exp_q[0].check_gap) begin
                    checkOutput("idle_gap", 32'(idle_cnt), 32'd1);
                end
            end
            cap_bits.push_back(bus.TX_OUT);
        end else begin
            if (capturing) begin
                capturing = 1'b0;
                compareFrame();
                idle_cnt = 0;
            end
            checkOutput("idle_line", 32'(bus.TX_OUT), 32'd1);
            idle_cnt++;
        end
    end

    function automatic exp_t makeExp(input logic [15:0] bits, input int nbits,
                                     input logic [4:0] prescale, input bit check_gap);
        exp_t e;
        e.bits      = bits;
        e.nbits     = nbits;
        e.prescale  = int'(prescale);
        e.check_gap = check_gap;
        return e;
    endfunction

    // Issues one request and checks the one-cycle acceptance latency.
    task automatic applyStimulus(input logic [7:0] data, input logic par_en,
                                 input logic par_typ, input logic [4:0] prescale,
                                 input logic [15:0] exp_bits, input int exp_nbits,
                                 input bit expect_frame);
        if (expect_frame) begin
            exp_q.push_back(makeExp(exp_bits, exp_nbits, prescale, 1'b0));
        end
        @(negedge CLK);
        bus.P_DATA     = data;
        bus.PAR_EN     = par_en;
        bus.PAR_TYP    = par_typ;
        bus.prescale   = prescale;
        bus.Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.Data_Valid = 1'b0;
        checkOutput("accept_busy", 32'(bus.Busy), 32'd1);
        checkOutput("accept_start", 32'(bus.TX_OUT), 32'd0);
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (bus.Busy !== 1'b0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("idle_in_time", 32'(n < budget), 32'd1);
    endtask

    initial begin
        int n;

        RST            = 1'b1;
        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = PAR_EVEN;
        bus.prescale   = '0;

        @(posedge CLK);
        #1;
        checkOutput("reset_tx", 32'(bus.TX_OUT), 32'd1);
        checkOutput("reset_busy", 32'(bus.Busy), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // 0xA5, no parity, one cycle per bit
        applyStimulus(8'hA5, 1'b0, PAR_EVEN, 5'd0, 16'b1_1010_0101_0, 10, 1'b1);
        waitIdle(100);

        // 0xA5 with even then odd parity, eight cycles per bit
        applyStimulus(8'hA5, 1'b1, PAR_EVEN, 5'd7,
                      PARITY_BUILD ? 16'b1_0_1010_0101_0 : 16'b1_1010_0101_0,
                      PARITY_BUILD ? 11 : 10, 1'b1);
        waitIdle(200);
        applyStimulus(8'hA5, 1'b1, PAR_ODD, 5'd7,
                      PARITY_BUILD ? 16'b1_1_1010_0101_0 : 16'b1_1010_0101_0,
                      PARITY_BUILD ? 11 : 10, 1'b1);
        waitIdle(200);

        // 0x07 (odd number of ones) with even parity, two cycles per bit
        applyStimulus(8'h07, 1'b1, PAR_EVEN, 5'd1,
                      PARITY_BUILD ? 16'b1_1_0000_0111_0 : 16'b1_0000_0111_0,
                      PARITY_BUILD ? 11 : 10, 1'b1);
        waitIdle(100);

        // Back-to-back: Data_Valid held high across 0x00 then 0xFF
        exp_q.push_back(makeExp(16'b1_0000_0000_0, 10, 5'd3, 1'b0));
        exp_q.push_back(makeExp(16'b1_1111_1111_0, 10, 5'd3, 1'b1));
        @(negedge CLK);
        bus.P_DATA     = 8'h00;
        bus.PAR_EN     = 1'b0;
        bus.prescale   = 5'd3;
        bus.Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.P_DATA = 8'hFF;
        n = 0;
        while (bus.Busy !== 1'b0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("b2b_first_done", 32'(n < 200), 32'd1);
        @(posedge CLK);
        #1;
        bus.Data_Valid = 1'b0;
        checkOutput("b2b_second_busy", 32'(bus.Busy), 32'd1);
        waitIdle(200);

        // Request pulsed mid-frame (ignored) plus prescale/PAR_EN changes
        applyStimulus(8'h81, 1'b0, PAR_EVEN, 5'd2, 16'b1_1000_0001_0, 10, 1'b1);
        repeat (6) @(posedge CLK);
        #1;
        bus.P_DATA     = 8'h3C;
        bus.prescale   = 5'd5;
        bus.PAR_EN     = 1'b1;
        bus.Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.Data_Valid = 1'b0;
        checkOutput("midframe_busy", 32'(bus.Busy), 32'd1);
        waitIdle(200);

        // Reset during data bit 4 of an abandoned 0x0F frame
        applyStimulus(8'h0F, 1'b0, PAR_EVEN, 5'd1, 16'h0000, 0, 1'b0);
        repeat (10) @(posedge CLK);
        #2;
        checkOutput("pre_reset_bit4", 32'(bus.TX_OUT), 32'd0);
        RST = 1'b1;
        #1;
        checkOutput("async_reset_tx", 32'(bus.TX_OUT), 32'd1);
        checkOutput("async_reset_busy", 32'(bus.Busy), 32'd0);
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #2;
        RST = 1'b0;

        // Fresh frame after reset
        applyStimulus(8'h55, 1'b0, PAR_EVEN, 5'd1, 16'b1_0101_0101_0, 10, 1'b1);
        waitIdle(100);

        repeat (4) @(negedge CLK);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
